// File: rtl/fetch_debug_ctrl_if.sv
// Link between the debug controller and the host-RX / fetch-stage side:
// received bytes and stop-pipe in, program-memory writes and step enable out.
interface fetch_debug_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic [7:0]        i_rx_data;
    logic              i_rx_done;
    logic              i_stop_pipe;
    logic              o_program_memory_write;
    logic [31:0]       o_instruction_write;
    logic [ADDR_W-1:0] o_address_write;
    logic              o_step;

    modport master (
        input  i_rx_data, i_rx_done, i_stop_pipe,
        output o_program_memory_write, o_instruction_write, o_address_write, o_step
    );

    modport slave (
        output i_rx_data, i_rx_done, i_stop_pipe,
        input  o_program_memory_write, o_instruction_write, o_address_write, o_step
    );
endinterface

// File: rtl/fetch_debug_ctrl.sv
// Host-driven debug sequencer for the fetch stage: loads instruction memory
// byte-wise, then runs the pipeline continuously or one step at a time.
module fetch_debug_ctrl #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                 clk,
    input  logic                 rst,
    fetch_debug_ctrl_if.master   bus,
    output logic [2:0]           o_state,
    output logic                 o_load_done,
    output logic                 o_load_overflow,
    output logic                 o_halted,
    output logic [31:0]          o_step_count
);
    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_NEXT = 8'h4E;
    localparam logic [7:0] CMD_END  = 8'h45;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOAD       = 3'd1,
        RUN        = 3'd2,
        STEP       = 3'd3,
        STEP_PULSE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [23:0]       word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              wr_q, wr_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic              step_q, step_d;
    logic              done_q, done_d;
    logic              ovf_q, ovf_d;
    logic              halted_q, halted_d;
    logic [31:0]       cnt_q, cnt_d;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_d     = word_q;
        addr_d     = addr_q;
        wr_d       = 1'b0;
        instr_d    = instr_q;
        waddr_d    = waddr_q;
        done_d     = done_q;
        ovf_d      = ovf_q;
        halted_d   = halted_q;
        cnt_d      = step_q ? sat_inc(cnt_q) : cnt_q;

        case (state_q)
            IDLE: begin
                if (bus.i_rx_done) begin
                    case (bus.i_rx_data)
                        CMD_LOAD: begin
                            state_d    = LOAD;
                            byte_cnt_d = 2'd0;
                            addr_d     = '0;
                            done_d     = 1'b0;
                            ovf_d      = 1'b0;
                            halted_d   = 1'b0;
                            cnt_d      = 32'd0;
                        end
                        CMD_RUN:  state_d = RUN;
                        CMD_STEP: state_d = STEP;
                        default:  state_d = IDLE;
                    endcase
                end
            end
            LOAD: begin
                // The termination decision is taken at the end of the write cycle,
                // once the written word and its address are on the outputs.
                if (wr_q) begin
                    addr_d = addr_q + 1'b1;
                    if (instr_q == HALT_WORD) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end else if (waddr_q == {ADDR_W{1'b1}}) begin
                        ovf_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                if (bus.i_rx_done && state_d == LOAD) begin
                    word_d     = {word_q[15:0], bus.i_rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        wr_d    = 1'b1;
                        instr_d = {word_q, bus.i_rx_data};
                        waddr_d = addr_q;
                    end
                end
            end
            RUN: begin
                if (bus.i_stop_pipe) begin
                    halted_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            STEP: begin
                if (bus.i_rx_done) begin
                    if (bus.i_rx_data == CMD_NEXT) begin
                        if (bus.i_stop_pipe) begin
                            halted_d = 1'b1;
                            state_d  = IDLE;
                        end else begin
                            state_d = STEP_PULSE;
                        end
                    end else if (bus.i_rx_data == CMD_END) begin
                        state_d = IDLE;
                    end
                end
            end
            STEP_PULSE: state_d = STEP;
            default:    state_d = IDLE;
        endcase

        // RUN steps from the cycle after entry; a step request pulses one cycle later.
        step_d = (state_d == RUN) || (state_q == STEP_PULSE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            byte_cnt_q <= 2'd0;
            word_q     <= 24'd0;
            addr_q     <= '0;
            wr_q       <= 1'b0;
            instr_q    <= 32'd0;
            waddr_q    <= '0;
            step_q     <= 1'b0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            halted_q   <= 1'b0;
            cnt_q      <= 32'd0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
            addr_q     <= addr_d;
            wr_q       <= wr_d;
            instr_q    <= instr_d;
            waddr_q    <= waddr_d;
            step_q     <= step_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            halted_q   <= halted_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.o_program_memory_write = wr_q;
    assign bus.o_instruction_write    = instr_q;
    assign bus.o_address_write        = waddr_q;
    assign bus.o_step                 = step_q;
    assign o_state                    = state_q;
    assign o_load_done                = done_q;
    assign o_load_overflow            = ovf_q;
    assign o_halted                   = halted_q;
    assign o_step_count               = cnt_q;
endmodule

// File: tb/tb_fetch_debug_ctrl.sv
// Bench for fetch_debug_ctrl: command table plus hand-written load/run/step/reset
// sequences, with expected memory writes checked through a scoreboard queue.
module tb_fetch_debug_ctrl;
    localparam int ADDR_W = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  o_state;
    logic        o_load_done, o_load_overflow, o_halted;
    logic [31:0] o_step_count;

    fetch_debug_ctrl_if #(.ADDR_W(ADDR_W)) bus();

    fetch_debug_ctrl #(.ADDR_W(ADDR_W), .HALT_WORD(32'hFFFF_FFFF)) dut (
        .clk             (clk),
        .rst             (rst),
        .bus             (bus),
        .o_state         (o_state),
        .o_load_done     (o_load_done),
        .o_load_overflow (o_load_overflow),
        .o_halted        (o_halted),
        .o_step_count    (o_step_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        logic [7:0] b;
        logic       stop;
        logic [2:0] st;
        int         steps;
        logic       halted;
    } vec_t;

    wr_t  exp_q[$];
    vec_t vecs[10];
    int   checks = 0;
    int   failures = 0;
    int   step_seen = 0;
    logic prev_wr = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard side: every write strobe is matched against the next expected write.
    always @(negedge clk) begin
        if (rst) begin
            if (bus.o_step) step_seen++;
            if (bus.o_program_memory_write) begin
                chk("wr_exclusive", {62'd0, bus.o_step, prev_wr}, 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", {30'd0, bus.o_address_write, bus.o_instruction_write}, 64'd0);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("write_addr_data", {30'd0, bus.o_address_write, bus.o_instruction_write},
                        {30'd0, e.addr, e.data});
                end
            end
            prev_wr = bus.o_program_memory_write;
        end else begin
            prev_wr = 1'b0;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit hold);
        @(posedge clk); #1;
        bus.i_rx_data = b;
        bus.i_rx_done = 1'b1;
        if (!hold) begin
            @(posedge clk); #1;
            bus.i_rx_done = 1'b0;
        end
    endtask

    task automatic end_burst();
        @(posedge clk); #1;
        bus.i_rx_done = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic [ADDR_W-1:0] a, input bit hold);
        wr_t e;
        logic [31:0] t;
        e.addr = a;
        e.data = w;
        exp_q.push_back(e);
        t = w;
        for (int k = 0; k < 4; k++) begin
            send_byte(t[31:24], hold);
            t = t << 8;
        end
    endtask

    task automatic check_status(input string tag, input logic [2:0] st, input logic done,
                                input logic ovf, input logic halted);
        chk({tag, "_state"}, {61'd0, o_state}, {61'd0, st});
        chk({tag, "_done"}, {63'd0, o_load_done}, {63'd0, done});
        chk({tag, "_ovf"}, {63'd0, o_load_overflow}, {63'd0, ovf});
        chk({tag, "_halted"}, {63'd0, o_halted}, {63'd0, halted});
    endtask

    task automatic check_reset_values(input string tag);
        check_status(tag, 3'd0, 1'b0, 1'b0, 1'b0);
        chk({tag, "_wr"}, {63'd0, bus.o_program_memory_write}, 64'd0);
        chk({tag, "_instr"}, {32'd0, bus.o_instruction_write}, 64'd0);
        chk({tag, "_addr"}, {62'd0, bus.o_address_write}, 64'd0);
        chk({tag, "_step"}, {63'd0, bus.o_step}, 64'd0);
        chk({tag, "_count"}, {32'd0, o_step_count}, 64'd0);
    endtask

    initial begin
        int s0;
        vecs[0] = '{8'h4E, 1'b0, 3'd0, 0, 1'b0};  // 'N' in IDLE ignored
        vecs[1] = '{8'h5A, 1'b0, 3'd0, 0, 1'b0};  // 'Z' in IDLE ignored
        vecs[2] = '{8'h53, 1'b0, 3'd3, 0, 1'b0};  // 'S' -> STEP
        vecs[3] = '{8'h58, 1'b0, 3'd3, 0, 1'b0};  // 'X' ignored in STEP
        vecs[4] = '{8'h4E, 1'b0, 3'd3, 1, 1'b0};  // 'N' -> one pulse
        vecs[5] = '{8'h4E, 1'b0, 3'd3, 1, 1'b0};
        vecs[6] = '{8'h45, 1'b0, 3'd0, 0, 1'b0};  // 'E' -> IDLE
        vecs[7] = '{8'h53, 1'b0, 3'd3, 0, 1'b0};
        vecs[8] = '{8'h4E, 1'b1, 3'd0, 0, 1'b1};  // 'N' with stop -> halt, no pulse
        vecs[9] = '{8'h43, 1'b1, 3'd0, 1, 1'b1};  // RUN with stop held -> one step

        bus.i_rx_data   = 8'h00;
        bus.i_rx_done   = 1'b0;
        bus.i_stop_pipe = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_values("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            bus.i_stop_pipe = vecs[i].stop;
            s0 = step_seen;
            send_byte(vecs[i].b, 1'b0);
            repeat (4) @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d_state", i), {61'd0, o_state}, {61'd0, vecs[i].st});
            chk($sformatf("vec%0d_steps", i), 64'(step_seen - s0), 64'(vecs[i].steps));
            chk($sformatf("vec%0d_halted", i), {63'd0, o_halted}, {63'd0, vecs[i].halted});
        end
        bus.i_stop_pipe = 1'b0;
        chk("table_step_count", {32'd0, o_step_count}, 64'd3);

        // Two-word load terminated by the halt word.
        send_byte(8'h4C, 1'b0);
        send_word(32'h0000_0001, 2'd0, 1'b0);
        send_word(32'hFFFF_FFFF, 2'd1, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_status("load", 3'd0, 1'b1, 1'b0, 1'b0);
        chk("load_count_cleared", {32'd0, o_step_count}, 64'd0);
        chk("load_queue_empty", 64'(exp_q.size()), 64'd0);

        // Fill all four words without a halt word.
        send_byte(8'h4C, 1'b0);
        for (int w = 0; w < 4; w++) send_word(32'h1111_1111, 2'(w), 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_status("ovf", 3'd0, 1'b0, 1'b1, 1'b0);
        chk("ovf_queue_empty", 64'(exp_q.size()), 64'd0);

        // Continuous run, with a 'C' byte arriving mid-run and stop raised 10 cycles in.
        s0 = step_seen;
        send_byte(8'h43, 1'b0);
        @(negedge clk);
        chk("run_first_step", {63'd0, bus.o_step}, 64'd1);
        repeat (3) @(posedge clk);
        #1;
        bus.i_rx_data = 8'h43;
        bus.i_rx_done = 1'b1;
        @(posedge clk); #1;
        bus.i_rx_done = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("run_state_mid", {61'd0, o_state}, 64'd2);
        @(posedge clk); #1;
        bus.i_stop_pipe = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("run_steps", 64'(step_seen - s0), 64'd11);
        chk("run_count", {32'd0, o_step_count}, 64'd11);
        check_status("run", 3'd0, 1'b0, 1'b1, 1'b1);
        bus.i_stop_pipe = 1'b0;

        // Step pulse lands two cycles after the 'N' strobe.
        send_byte(8'h53, 1'b0);
        send_byte(8'h4E, 1'b0);
        @(negedge clk);
        chk("step_lat_c1", {63'd0, bus.o_step}, 64'd0);
        @(negedge clk);
        chk("step_lat_c2", {63'd0, bus.o_step}, 64'd1);
        @(negedge clk);
        chk("step_lat_c3", {63'd0, bus.o_step}, 64'd0);
        chk("step_count_12", {32'd0, o_step_count}, 64'd12);
        send_byte(8'h45, 1'b0);
        @(negedge clk);
        chk("step_exit_state", {61'd0, o_state}, 64'd0);

        // Reset in the middle of a word, then a back-to-back reload.
        send_byte(8'h4C, 1'b0);
        send_byte(8'h12, 1'b0);
        send_byte(8'h34, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check_reset_values("midload_rst");
        @(posedge clk); #1;
        rst = 1'b1;
        send_byte(8'h4C, 1'b0);
        send_word(32'hDEAD_BEEF, 2'd0, 1'b1);
        send_word(32'hFFFF_FFFF, 2'd1, 1'b1);
        end_burst();
        repeat (4) @(posedge clk);
        @(negedge clk);
        check_status("reload", 3'd0, 1'b1, 1'b0, 1'b0);
        chk("reload_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_debug_ctrl.md
# fetch_debug_ctrl

Debug controller that sequences the instruction-fetch stage from a byte-oriented host link (UART receiver). It loads the instruction memory through the fetch stage's program-write port. It then runs the pipeline either continuously or one clock at a time by driving the fetch stage's step enable. Execution halts on the fetch stage's stop-pipe indication. It sits between the UART RX block and the fetch stage and is the only source of program-memory writes and step pulses.

## Interface
- ADDR_W, 8, instruction-memory word-address width; depth = 2^ADDR_W words
- HALT_WORD, 32'hFFFF_FFFF, word that terminates a load (also the instruction the stop-pipe detector flags)
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- i_rx_data  in  8  received byte, valid only when i_rx_done=1
- i_rx_done  in  1  one-cycle strobe, one per received byte
- i_stop_pipe  in  1  stop-pipe indication from the fetch stage
- o_program_memory_write  out  1  one-cycle instruction-memory write strobe
- o_instruction_write  out  32  word to write
- o_address_write  out  ADDR_W  word address to write
- o_step  out  1  pipeline advance enable (PC/stage update)
- o_state  out  3  current FSM state encoding, for host/LED readout
- o_load_done  out  1  sticky: last load ended with HALT_WORD
- o_load_overflow  out  1  sticky: last load filled memory without HALT_WORD
- o_halted  out  1  sticky: execution stopped on i_stop_pipe
- o_step_count  out  32  clocks with o_step=1 since last load

## Operation
- Commands are single bytes accepted only in IDLE: 'L' (0x4C) load, 'C' (0x43) continuous run, 'S' (0x53) step mode. Any other byte in IDLE is ignored.
- States and encodings: IDLE=0, LOAD=1, RUN=2, STEP=3, STEP_PULSE=4.
- IDLE
  - 'L' → LOAD: clears address counter, byte counter, o_load_done, o_load_overflow, o_halted, o_step_count.
  - 'C' → RUN.
  - 'S' → STEP.
- LOAD
  - Bytes are assembled MSB first: the first byte goes to [31:24] and the fourth to [7:0].
  - On the 4th byte, the cycle after its i_rx_done:
    - o_program_memory_write=1 for exactly one cycle.
    - o_instruction_write = assembled word.
    - o_address_write = current address.
    - The address counter increments at the end of that cycle.
  - If the written word == HALT_WORD: set o_load_done and go to IDLE. The halt word is itself written.
  - Else, if the address written was 2^ADDR_W-1: set o_load_overflow and go to IDLE. The counter wraps to 0 but is unused.
  - A byte arriving during the write cycle is captured as byte 0 of the next word.
- RUN
  - o_step=1 every cycle, starting the cycle after entry.
  - When i_stop_pipe is sampled 1: o_step=0 from the next cycle, set o_halted, go to IDLE.
  - Bytes received in RUN are ignored.
- STEP
  - o_step=0.
  - 'N' (0x4E) with i_stop_pipe=0 → STEP_PULSE.
  - 'N' with i_stop_pipe=1 → set o_halted, go to IDLE, no pulse.
  - 'E' (0x45) → IDLE.
  - Other bytes are ignored.
- STEP_PULSE: o_step=1 for exactly one cycle, then return to STEP.
- o_step_count increments by 1 on every cycle with o_step=1 and saturates at 32'hFFFF_FFFF.
- o_program_memory_write and o_step are never 1 in the same cycle.

## Timing
- Reset (rst=0, asynchronous), all outputs:
  - State=IDLE.
  - o_program_memory_write=0, o_instruction_write=0, o_address_write=0.
  - o_step=0, o_state=0.
  - o_load_done=0, o_load_overflow=0, o_halted=0, o_step_count=0.
- Reset asserted mid-load or mid-run aborts immediately. A partial word is discarded.
- All outputs are registered. Command latency: the state changes on the edge that samples i_rx_done.
- Load word latency: write strobe 1 cycle after the 4th byte's i_rx_done.
- RUN: first o_step=1 one cycle after the 'C' strobe.
- Halt latency: o_step drops 1 cycle after i_stop_pipe is first seen high. At most one extra step reaches the PC after the halt instruction is fetched; fetch-stage hazard logic absorbs it.
- Re-entering RUN with i_stop_pipe still 1 produces exactly one o_step cycle, then halts.
- Step: a single o_step pulse 2 cycles after the 'N' strobe.

## Test plan
- Load: 'L', 00 00 00 01, FF FF FF FF → two writes:
  - addr 0 = 0x00000001, addr 1 = 0xFFFFFFFF.
  - o_load_done=1, state IDLE.
  - Each o_program_memory_write is 1 cycle wide.
- Overflow (ADDR_W=2): 'L', then 16 bytes of 0x11 → writes to addresses 0–3; o_load_overflow=1, o_load_done=0.
- Run: 'C', i_stop_pipe raised 10 cycles after o_step rises → o_step high exactly 11 cycles, o_halted=1, o_step_count=11.
- Step: 'S', 'N', 'N', 'X', 'E' → exactly two 1-cycle o_step pulses, 'X' ignored, ends in IDLE; 'N' with i_stop_pipe=1 → no pulse, o_halted=1.
- Reset mid-load after 2 bytes of a word → all outputs at reset values; a fresh 'L' load writes from address 0 with correct words.
- Bytes 'N' and 'Z' received in IDLE, and 'C' received in RUN → no state change, no o_step or write side effects.
